// File: rtl/ram_stack_ctrl.sv
// ram_stack_ctrl: LIFO stack controller driving a single-port RAM with combinational read.
// Optional feature macro: STACK_ERR_STICKY_EN (OVF/UDF stay set until RST instead of pulsing).
module ram_stack_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [WIDTH-1:0]      DIN,
    output logic [WIDTH-1:0]      DOUT,
    output logic                  VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVF,
    output logic                  UDF,
    output logic                  RAM_CE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [WIDTH-1:0]      RAM_DIN,
    input  logic [WIDTH-1:0]      RAM_DOUT
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] sp_q, sp_d;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [ADDR_WIDTH:0] sp_top;
    logic                full, empty;
    logic                do_push, do_pop, do_replace, do_seed;
    logic                ovf_ev, udf_ev;

    // Status flags and operation decode, all combinational from SP and the strobes
    always_comb begin
        full       = (sp_q == DEPTH);
        empty      = (sp_q == '0);
        sp_top     = sp_q - ONE;
        do_replace = PUSH && POP && !empty;
        do_seed    = PUSH && POP && empty;
        do_push    = PUSH && !POP && !full;
        do_pop     = POP && !PUSH && !empty;
        ovf_ev     = PUSH && !POP && full;
        udf_ev     = POP && empty;
    end

    // RAM interface: write at SP for pushes, address the top entry otherwise (0 when empty)
    always_comb begin
        RAM_CE   = !RST && (do_push || do_seed || do_replace);
        RAM_ADDR = (do_push || do_seed || ovf_ev) ? sp_q[ADDR_WIDTH-1:0] :
                   empty ? '0 : sp_top[ADDR_WIDTH-1:0];
        RAM_DIN  = DIN;
    end

    // Next-state: pointer moves on push/pop, DOUT captures the old top on pop or replace
    always_comb begin
        sp_d    = (do_push || do_seed) ? sp_q + ONE : do_pop ? sp_top : sp_q;
        dout_d  = (do_pop || do_replace) ? RAM_DOUT : dout_q;
        valid_d = do_pop || do_replace;
`ifdef STACK_ERR_STICKY_EN
        ovf_d   = ovf_q || ovf_ev;
        udf_d   = udf_q || udf_ev;
`else
        ovf_d   = ovf_ev;
        udf_d   = udf_ev;
`endif
    end

    // State registers with synchronous reset; RAM contents are left untouched
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;
    assign FULL  = full;
    assign EMPTY = empty;
    assign COUNT = sp_q;
endmodule

// File: doc/ram_stack_ctrl.md
Name: ram_stack_ctrl

Overview:
- LIFO stack controller placed directly upstream of the single-port RAM. It drives the RAM's write enable, address and write data, and reads back the RAM's combinational read data.
- Converts PUSH/POP strobes from the CPU control unit into RAM accesses. Maintains the stack pointer, full/empty status and error flags.
- Holds popped data in a register so the datapath sees a stable value.

Parameters:
ADDR_WIDTH, 8, RAM address width; stack depth = 2**ADDR_WIDTH words
WIDTH, 8, data word width (must match the RAM)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
PUSH  input  1  push request, sampled every cycle
POP  input  1  pop request, sampled every cycle
DIN  input  WIDTH  word to push
DOUT  output  WIDTH  registered last-popped word
VALID  output  1  one-cycle pulse, DOUT updated this cycle
FULL  output  1  COUNT == 2**ADDR_WIDTH
EMPTY  output  1  COUNT == 0
COUNT  output  ADDR_WIDTH+1  current number of stored entries
OVF  output  1  overflow: push attempted while full
UDF  output  1  underflow: pop attempted while empty
RAM_CE  output  1  RAM write enable
RAM_ADDR  output  ADDR_WIDTH  RAM address
RAM_DIN  output  WIDTH  RAM write data; always equals DIN
RAM_DOUT  input  WIDTH  RAM combinational read data

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset: when RST is high at a clock edge, SP (= COUNT) <= 0, DOUT <= 0, VALID <= 0, OVF <= 0, UDF <= 0.
  - RAM contents are not cleared.
  - RAM_CE is forced to 0 while RST is high, so reset during a push writes nothing.
- Stack growth: the stack grows upward. SP is the next free address and RAM_ADDR is SP truncated to ADDR_WIDTH. The top of stack is SP-1.
- FULL, EMPTY and COUNT are combinational from SP.
- Push only (PUSH=1, POP=0, not FULL):
  - RAM_ADDR = SP, RAM_CE = 1 combinationally.
  - The RAM writes at the edge; SP <= SP+1.
- Pop only (POP=1, PUSH=0, not EMPTY):
  - RAM_ADDR = SP-1, RAM_CE = 0.
  - At the edge: DOUT <= RAM_DOUT, SP <= SP-1, VALID <= 1.
  - Latency: DOUT is valid the cycle after POP, marked by VALID.
- Both asserted, not EMPTY (replace top):
  - RAM_ADDR = SP-1, RAM_CE = 1.
  - At the edge: DOUT <= old top (RAM_DOUT), RAM[SP-1] <= DIN, VALID <= 1, SP unchanged. Valid even when FULL.
- Both asserted, EMPTY:
  - Treated as a push: write at address 0, SP <= 1.
  - VALID = 0 and UDF pulses.
- Push while FULL (without POP):
  - RAM_CE = 0, SP unchanged, OVF pulses.
  - SP never wraps past 2**ADDR_WIDTH.
- Pop while EMPTY (without PUSH):
  - SP unchanged, DOUT holds its value, VALID = 0, UDF pulses.
  - SP never wraps below 0.
- Idle (neither asserted):
  - RAM_CE = 0. RAM_ADDR = SP-1 when not EMPTY, else 0 (top-of-stack preview).
  - VALID <= 0.
- OVF and UDF are registered. By default each is a one-cycle pulse in the cycle after the offending request.
- Address width: SP is ADDR_WIDTH+1 bits. RAM_ADDR uses only the low ADDR_WIDTH bits. When FULL, SP's low bits are 0, but no write occurs because RAM_CE is gated off.

Optional Feature:
- Macro: STACK_ERR_STICKY_EN.
- Defined: OVF and UDF are sticky. Once set they remain 1 until RST; further errors keep them set.
- Not defined: OVF and UDF are single-cycle pulses as described in Behaviour.

Test Plan:
- ADDR_WIDTH=2. After RST: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> COUNT 1..4, FULL=1 after the 4th, RAM[0..3] = 11,22,33,44.
- From full, push 0x55 -> OVF=1 for one cycle, COUNT stays 4, RAM[0] still 0x11. With STACK_ERR_STICKY_EN, OVF stays 1 until RST.
- Pop 4 times -> DOUT = 0x44, 0x33, 0x22, 0x11 each with VALID=1, then EMPTY=1. A 5th pop -> UDF=1, VALID=0, DOUT stays 0x11.
- Stack {0xA0, 0xB1}, PUSH=POP=1 with DIN=0xC2 -> DOUT=0xB1, VALID=1, COUNT stays 2, RAM[1]=0xC2. Then on an empty stack, PUSH=POP=1 with DIN=0x07 -> COUNT=1, RAM[0]=0x07, UDF pulse, VALID=0.
- Assert RST in the same cycle as PUSH with COUNT=2 -> RAM_CE=0, no write, COUNT=0, DOUT=0, VALID=0, OVF=UDF=0 next cycle.
- Idle with stack {0x5A} -> RAM_ADDR=0, RAM_CE=0. Idle with an empty stack -> RAM_ADDR=0, RAM_CE=0, EMPTY=1.
